hazard_scoreboard: RTL and testbench

- Interlock controller for the 5-stage pipeline.
- Tracks destination registers of in-flight instructions between decode and writeback commit in a shift-register scoreboard.
- Compares them against the decode-stage source operands and valid bits produced by the decode register-identifier logic.
- When a RAW hazard exists, stalls fetch/decode and injects bubbles into ID/EX. Also supports wrong-path flush, global freeze and a stall-cycle counter.

---
 rtl/hazard_scoreboard.sv | 125 ++++++++++++
 tb/tb_hazard_scoreboard.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//
// Interlock controller for the 5-stage pipeline. A shift-register
// scoreboard tracks the destination registers of in-flight instructions.
// Entry 0 is EX and entry DEPTH-1 is WB. The scoreboard is compared
// against the decode-stage source operands. On a RAW hazard the block
// stalls fetch/decode and injects bubbles into ID/EX. There is no
// forwarding, so a stall lasts until the producer leaves the compared set.
//
// Parameters:
//   DEPTH      scoreboard entries (2..4)
//   WB_BYPASS  1: the WB entry is excluded from the compare because the
//              register file writes before it reads
//   CNT_W      width of the saturating stall counter
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   id_valid            decode stage holds a real instruction
//   id_rs/id_rs_valid   decode source Rs and its read enable
//   id_rt/id_rt_valid   decode source Rt and its read enable
//   id_rd/id_rd_valid   decode destination and its write enable
//   flush               kill the decode instruction (taken branch in EX)
//   freeze              global pipeline hold
//   stall               hold PC and IF/ID this cycle
//   bubble              load a NOP into ID/EX at the next edge
//   inflight_mask       one-hot OR of valid scoreboard destinations
//   stall_count         saturating count of hazard-stall cycles

module hazard_scoreboard #(
    parameter int DEPTH     = 3,
    parameter int WB_BYPASS = 1,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [2:0]       id_rs,
    input  logic             id_rs_valid,
    input  logic [2:0]       id_rt,
    input  logic             id_rt_valid,
    input  logic [2:0]       id_rd,
    input  logic             id_rd_valid,
    input  logic             flush,
    input  logic             freeze,
    output logic             stall,
    output logic             bubble,
    output logic [7:0]       inflight_mask,
    output logic [CNT_W-1:0] stall_count
);

    // With write-before-read in the register file, the WB entry can never
    // cause a hazard, so it is left out of the compare.
    localparam int CMP_N = (WB_BYPASS != 0) ? DEPTH - 1 : DEPTH;

    logic [DEPTH-1:0]      valid_q, valid_d;
    logic [DEPTH-1:0][2:0] dest_q, dest_d;
    logic [CNT_W-1:0]      stall_count_q, stall_count_d;

    logic match;
    logic hazard;
    logic [7:0] mask;

    // Source-operand compare against the older in-flight writers. A decode
    // instruction is never in the scoreboard itself, so it cannot hazard on
    // its own destination.
    always_comb begin
        match = 1'b0;
        mask  = 8'd0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i]) begin
                mask = mask | (8'd1 << dest_q[i]);
                if (i < CMP_N) begin
                    if ((id_rs_valid && (dest_q[i] == id_rs)) ||
                        (id_rt_valid && (dest_q[i] == id_rt))) begin
                        match = 1'b1;
                    end
                end
            end
        end
        hazard = id_valid && !flush && match;
    end

    assign stall         = hazard;
    assign bubble        = (hazard || flush) && !freeze;
    assign inflight_mask = mask;
    assign stall_count   = stall_count_q;

    // Freeze holds everything and outranks hazard and flush. Otherwise the
    // scoreboard advances one stage; the decode instruction enters only if
    // it actually issues (no hazard, not flushed) and writes a register.
    always_comb begin
        valid_d       = valid_q;
        dest_d        = dest_q;
        stall_count_d = stall_count_q;
        if (!freeze) begin
            for (int i = DEPTH - 1; i >= 1; i--) begin
                valid_d[i] = valid_q[i-1];
                dest_d[i]  = dest_q[i-1];
            end
            if (id_valid && id_rd_valid && !hazard && !flush) begin
                valid_d[0] = 1'b1;
                dest_d[0]  = id_rd;
            end else begin
                valid_d[0] = 1'b0;
                dest_d[0]  = 3'd0;
            end
            if (hazard && (stall_count_q != {CNT_W{1'b1}})) begin
                stall_count_d = stall_count_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q       <= '0;
            dest_q        <= '0;
            stall_count_q <= '0;
        end else begin
            valid_q       <= valid_d;
            dest_q        <= dest_d;
            stall_count_q <= stall_count_d;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard
//
// Drives three scoreboard configurations from one shared input stream:
//   a: DEPTH=3, WB_BYPASS=1, CNT_W=16
//   b: DEPTH=3, WB_BYPASS=1, CNT_W=4  (counter saturation)
//   c: DEPTH=4, WB_BYPASS=0, CNT_W=16
// Each configuration has a reference model. The model is a list of
// in-flight destinations, where -1 means empty, plus an integer stall
// count with a cap.

module tb_hazard_scoreboard;

    logic       clk;
    logic       rst_n;
    logic       id_valid;
    logic [2:0] id_rs;
    logic       id_rs_valid;
    logic [2:0] id_rt;
    logic       id_rt_valid;
    logic [2:0] id_rd;
    logic       id_rd_valid;
    logic       flush;
    logic       freeze;

    logic        stall_a, bubble_a, stall_b, bubble_b, stall_c, bubble_c;
    logic [7:0]  mask_a, mask_b, mask_c;
    logic [15:0] count_a, count_c;
    logic [3:0]  count_b;

    int num_vectors;
    int num_miscompares;

    // Reference state: in-flight destinations (index 0 = EX, -1 = empty).
    int q_ab[4];
    int q_c[4];
    int cnt_a, cnt_b, cnt_c;

    hazard_scoreboard #(.DEPTH(3), .WB_BYPASS(1), .CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_rs(id_rs), .id_rs_valid(id_rs_valid),
        .id_rt(id_rt), .id_rt_valid(id_rt_valid),
        .id_rd(id_rd), .id_rd_valid(id_rd_valid),
        .flush(flush), .freeze(freeze),
        .stall(stall_a), .bubble(bubble_a),
        .inflight_mask(mask_a), .stall_count(count_a)
    );

    hazard_scoreboard #(.DEPTH(3), .WB_BYPASS(1), .CNT_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_rs(id_rs), .id_rs_valid(id_rs_valid),
        .id_rt(id_rt), .id_rt_valid(id_rt_valid),
        .id_rd(id_rd), .id_rd_valid(id_rd_valid),
        .flush(flush), .freeze(freeze),
        .stall(stall_b), .bubble(bubble_b),
        .inflight_mask(mask_b), .stall_count(count_b)
    );

    hazard_scoreboard #(.DEPTH(4), .WB_BYPASS(0), .CNT_W(16)) dut_c (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_rs(id_rs), .id_rs_valid(id_rs_valid),
        .id_rt(id_rt), .id_rt_valid(id_rt_valid),
        .id_rd(id_rd), .id_rd_valid(id_rd_valid),
        .flush(flush), .freeze(freeze),
        .stall(stall_c), .bubble(bubble_c),
        .inflight_mask(mask_c), .stall_count(count_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got,
                               input logic [31:0] exp);
        num_vectors++;
        if (got !== exp) begin
            num_miscompares++;
            $display("[TB] FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // A decode read conflicts with any of the first ncmp in-flight writers.
    function automatic bit modelHazard(input int q[4], input int ncmp);
        bit m = 1'b0;
        for (int i = 0; i < ncmp; i++) begin
            if (q[i] >= 0) begin
                if ((id_rs_valid && q[i] == int'(id_rs)) ||
                    (id_rt_valid && q[i] == int'(id_rt))) m = 1'b1;
            end
        end
        return id_valid && !flush && m;
    endfunction

    function automatic logic [7:0] modelMask(input int q[4], input int depth);
        logic [7:0] m = 8'd0;
        for (int i = 0; i < depth; i++) begin
            if (q[i] >= 0) m[q[i]] = 1'b1;
        end
        return m;
    endfunction

    function automatic void clearModel();
        for (int i = 0; i < 4; i++) begin
            q_ab[i] = -1;
            q_c[i]  = -1;
        end
        cnt_a = 0;
        cnt_b = 0;
        cnt_c = 0;
    endfunction

    // Drive one decode cycle at the falling edge, check combinational
    // outputs shortly after, then advance the model across the rising edge.
    task automatic applyStimulus(input logic v, input logic [2:0] rs, input logic rsv,
                                 input logic [2:0] rt, input logic rtv,
                                 input logic [2:0] rd, input logic rdv,
                                 input logic fl, input logic fz);
        bit hz_ab, hz_c;
        id_valid = v;   id_rs = rs; id_rs_valid = rsv;
        id_rt = rt;     id_rt_valid = rtv;
        id_rd = rd;     id_rd_valid = rdv;
        flush = fl;     freeze = fz;
        #1;
        hz_ab = modelHazard(q_ab, 2);
        hz_c  = modelHazard(q_c, 4);
        checkOutput("stall_a",  32'(stall_a),  32'(hz_ab));
        checkOutput("bubble_a", 32'(bubble_a), 32'((hz_ab || fl) && !fz));
        checkOutput("mask_a",   32'(mask_a),   32'(modelMask(q_ab, 3)));
        checkOutput("count_a",  32'(count_a),  32'(cnt_a));
        checkOutput("stall_b",  32'(stall_b),  32'(hz_ab));
        checkOutput("bubble_b", 32'(bubble_b), 32'((hz_ab || fl) && !fz));
        checkOutput("mask_b",   32'(mask_b),   32'(modelMask(q_ab, 3)));
        checkOutput("count_b",  32'(count_b),  32'(cnt_b));
        checkOutput("stall_c",  32'(stall_c),  32'(hz_c));
        checkOutput("bubble_c", 32'(bubble_c), 32'((hz_c || fl) && !fz));
        checkOutput("mask_c",   32'(mask_c),   32'(modelMask(q_c, 4)));
        checkOutput("count_c",  32'(count_c),  32'(cnt_c));
        @(posedge clk);
        if (!fz) begin
            for (int i = 3; i >= 1; i--) begin
                q_ab[i] = q_ab[i-1];
                q_c[i]  = q_c[i-1];
            end
            q_ab[3] = -1;
            q_ab[0] = (v && rdv && !hz_ab && !fl) ? int'(rd) : -1;
            q_c[0]  = (v && rdv && !hz_c  && !fl) ? int'(rd) : -1;
            if (hz_ab && cnt_a < 65535) cnt_a++;
            if (hz_ab && cnt_b < 15)    cnt_b++;
            if (hz_c  && cnt_c < 65535) cnt_c++;
        end
        @(negedge clk);
    endtask

    // Assert reset between edges and expect cleared outputs without a clock.
    task automatic midReset();
        rst_n = 1'b0;
        #1;
        checkOutput("rst_mask_a",  32'(mask_a),  32'd0);
        checkOutput("rst_stall_a", 32'(stall_a), 32'd0);
        checkOutput("rst_count_a", 32'(count_a), 32'd0);
        checkOutput("rst_mask_c",  32'(mask_c),  32'd0);
        checkOutput("rst_count_b", 32'(count_b), 32'd0);
        clearModel();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        num_vectors     = 0;
        num_miscompares = 0;
        clearModel();
        rst_n = 1'b0;
        id_valid = 0; id_rs = 0; id_rs_valid = 0; id_rt = 0; id_rt_valid = 0;
        id_rd = 0; id_rd_valid = 0; flush = 0; freeze = 0;
        #2;
        checkOutput("init_mask_a",   32'(mask_a),   32'd0);
        checkOutput("init_stall_a",  32'(stall_a),  32'd0);
        checkOutput("init_bubble_a", 32'(bubble_a), 32'd0);
        checkOutput("init_count_a",  32'(count_a),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Fill with r1, r2, r3 and reset mid-stream.
        applyStimulus(1, 0, 0, 0, 0, 1, 1, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 2, 1, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 3, 1, 0, 0);
        midReset();

        // RAW distance 1: ADD r3<-r1,r2 then SUB r4<-r3,r5 held until it issues.
        applyStimulus(1, 1, 1, 2, 1, 3, 1, 0, 0);
        for (int i = 0; i < 4; i++) applyStimulus(1, 3, 1, 5, 1, 4, 1, 0, 0);
        checkOutput("raw_count_a", 32'(count_a), 32'd2);

        // No hazard: ADD r3 then ADDI r6<-r5 with Rt ignored.
        midReset();
        applyStimulus(1, 1, 1, 2, 1, 3, 1, 0, 0);
        checkOutput("nohaz_mask_a", 32'(mask_a), 32'h08);
        applyStimulus(1, 5, 1, 3, 0, 6, 1, 0, 0);
        checkOutput("nohaz_mask2_a", 32'(mask_a), 32'h48);

        // Flush while a hazard is present.
        midReset();
        applyStimulus(1, 1, 1, 2, 1, 3, 1, 0, 0);
        applyStimulus(1, 3, 1, 0, 0, 4, 1, 1, 0);
        checkOutput("flush_mask_a", 32'(mask_a), 32'h08);

        // Freeze with a hazard present for 4 cycles, then resolve.
        midReset();
        applyStimulus(1, 1, 1, 2, 1, 3, 1, 0, 0);
        for (int i = 0; i < 4; i++) applyStimulus(1, 3, 1, 5, 1, 4, 1, 0, 1);
        for (int i = 0; i < 3; i++) applyStimulus(1, 3, 1, 5, 1, 4, 1, 0, 0);
        checkOutput("freeze_count_a", 32'(count_a), 32'd2);

        // Repeatedly re-enter the writer so the 4-bit counter saturates.
        midReset();
        for (int k = 0; k < 12; k++) begin
            applyStimulus(1, 0, 0, 0, 0, 3, 1, 0, 0);
            applyStimulus(1, 3, 1, 3, 1, 5, 1, 0, 0);
            applyStimulus(1, 3, 1, 3, 1, 5, 1, 0, 0);
        end
        checkOutput("sat_count_b", 32'(count_b), 32'd15);

        // Random traffic on a small register set for frequent hazards.
        for (int n = 0; n < 500; n++) begin
            if (n == 250) midReset();
            applyStimulus(($urandom_range(0, 99) < 85) ? 1'b1 : 1'b0,
                          3'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
                          3'($urandom_range(0, 3)), ($urandom_range(0, 1) != 0) ? 1'b1 : 1'b0,
                          3'($urandom_range(0, 7)), ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
                          ($urandom_range(0, 9) == 0) ? 1'b1 : 1'b0,
                          ($urandom_range(0, 9) == 0) ? 1'b1 : 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", num_vectors, num_miscompares);
        $finish;
    end

endmodule
